pipelined_rca: RTL
==================

PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits, minimum 2.
REQ-002 SHALL have parameter STAGES, default 4: number of carry-chain pipeline stages, minimum 1; WIDTH % STAGES == 0 is required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have in_valid  input  1: the upstream operands are valid.
REQ-006 SHALL have in_ready  output  1: the block accepts operands this cycle.
REQ-007 SHALL have a, b  input  WIDTH: the operands.
REQ-008 SHALL have cin  input  1: the carry-in.
REQ-009 SHALL have out_valid  output  1: the result is valid.
REQ-010 SHALL have out_ready  input  1: the downstream accepts the result.
REQ-011 SHALL have sum  output  WIDTH: the result.
REQ-012 SHALL have cout  output  1: the carry-out of the MSB.
REQ-013 SHALL have ovf  output  1: two's-complement overflow (carry into the MSB XOR carry out of the MSB).

Function
REQ-014 SHALL split the operands into STAGES chunks of CHUNK = WIDTH/STAGES bits; stage k adds chunk k (LSB first) using the carry registered from stage k-1.
REQ-015 SHALL carry unprocessed upper operand chunks and completed lower sum chunks forward in per-stage registers, with each stage's sum chunk registered once and then passed on unchanged.
REQ-016 SHALL give latency of exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, with no downstream stall.
REQ-017 SHALL give throughput of one transaction per cycle when out_ready stays high.
REQ-018 SHALL keep a valid bit per stage; a stage advances when it is empty or the next stage advances; the last stage advances on out_ready or when it is empty.
REQ-019 SHALL drive in_ready = !valid[0] | stage-0 advances, combinationally from out_ready through the valid chain, with no bubble insertion.
REQ-020 SHALL hold sum, cout and ovf stable while out_valid & !out_ready, and SHALL hold all stage contents.
REQ-021 SHALL accept a new transaction and deliver the last-stage result in the same cycle without loss or duplication.
REQ-022 SHALL deliver results in acceptance order, with at most STAGES transactions in flight.
REQ-023 SHALL ignore in_valid when in_ready is low, and SHALL hold operands unsampled.
REQ-024 SHALL compute sum/cout modulo 2^WIDTH exactly, including all-ones + 1 with carry rippling through every stage.
REQ-025 SHALL behave with STAGES == 1 as a single registered adder with latency 1.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously clear all valid bits, giving out_valid=0 and in_ready=1.
REQ-027 SHALL, while rst_n is low, clear sum, cout, ovf and all stage data/carry registers to 0.
REQ-028 SHALL discard in-flight transactions on reset mid-operation, with no output produced for them after reset release.

Configuration
REQ-029 SHALL, with PIPELINED_RCA_SUB_EN defined, add an input sub (1 bit, travels with the operands): when sub=1 the block computes a + ~b + 1 (cin ignored), cout=1 means no borrow, and ovf applies to signed subtraction.
REQ-030 SHALL, without PIPELINED_RCA_SUB_EN, have no sub port and compute a + b + cin only.

Structure
REQ-031 SHALL place the CHUNK derivation helper and the reset-value constants in the shared package pipelined_rca_pkg.
REQ-032 SHALL use one sub-module, rca_chunk: a combinational CHUNK-bit ripple adder (a, b, cin -> s, cout, MSB carry-in for ovf), instantiated STAGES times.

Verification
REQ-033 SHALL cover, at WIDTH=16, STAGES=4: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, with out_valid exactly 4 cycles after acceptance.
REQ-034 SHALL cover: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (full-chain ripple).
REQ-035 SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-036 SHALL cover: 8 back-to-back transactions with out_ready low for cycles 5-7 -> in_ready low once 4 are held, all 8 results in order, none lost or duplicated.
REQ-037 SHALL cover: rst_n pulsed low with 3 transactions in flight -> out_valid=0 and in_ready=1 immediately, and no stale result after release.
REQ-038 SHALL cover, with PIPELINED_RCA_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Reset values and the per-stage chunk width derivation live here.
package pipelined_rca_pkg;

  localparam logic VLD_RST  = 1'b0;
  localparam logic DATA_RST = 1'b0;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_rca_chunk.sv
// rca_chunk: combinational W-bit ripple adder; also exposes the carry
// into its MSB so the top can form two's-complement overflow.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder, one CHUNK-bit slice per stage, with
// valid/ready flow control. Define PIPELINED_RCA_SUB_EN to add a sub input.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0]             adv;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
  logic [STAGES-1:0]             c_q, m_q;

  logic [STAGES-1:0][CHUNK-1:0]  ca_w, cb_w, cs_w;
  logic [STAGES-1:0]             ci_w, co_w, cm_w;

  logic [WIDTH-1:0]              b_in;
  logic                          c_in;

`ifdef PIPELINED_RCA_SUB_EN
  // Subtraction is a + ~b + 1; b is stored already inverted so later stages never see sub.
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign ca_w[k] = a[CHUNK-1:0];
      assign cb_w[k] = b_in[CHUNK-1:0];
      assign ci_w[k] = c_in;
    end else begin : g_rest
      assign ca_w[k] = a_q[k-1][k*CHUNK +: CHUNK];
      assign cb_w[k] = b_q[k-1][k*CHUNK +: CHUNK];
      assign ci_w[k] = c_q[k-1];
    end

    rca_chunk #(.W(CHUNK)) u_chunk (
      .a     (ca_w[k]),
      .b     (cb_w[k]),
      .cin   (ci_w[k]),
      .s     (cs_w[k]),
      .cout  (co_w[k]),
      .c_msb (cm_w[k])
    );
  end

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv           = '0;
    adv[STAGES-1] = !vld_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !vld_q[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {STAGES{VLD_RST}};
      a_q   <= {(STAGES*WIDTH){DATA_RST}};
      b_q   <= {(STAGES*WIDTH){DATA_RST}};
      s_q   <= {(STAGES*WIDTH){DATA_RST}};
      c_q   <= {STAGES{DATA_RST}};
      m_q   <= {STAGES{DATA_RST}};
    end else begin
      // Stage 0: sample operands and add the lowest chunk.
      if (adv[0]) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          a_q[0]            <= a;
          b_q[0]            <= b_in;
          s_q[0]            <= {WIDTH{DATA_RST}};
          s_q[0][CHUNK-1:0] <= cs_w[0];
          c_q[0]            <= co_w[0];
          m_q[0]            <= cm_w[0];
        end
      end
      // Stages 1..STAGES-1: add chunk k, pass completed lower chunks through.
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            a_q[k]                   <= a_q[k-1];
            b_q[k]                   <= b_q[k-1];
            s_q[k]                   <= s_q[k-1];
            s_q[k][k*CHUNK +: CHUNK] <= cs_w[k];
            c_q[k]                   <= co_w[k];
            m_q[k]                   <= cm_w[k];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = m_q[STAGES-1] ^ c_q[STAGES-1];

  // Already-consumed operand chunks and intermediate MSB carries are dead bits.
  logic unused_ok;
  assign unused_ok = ^{a_q, b_q, m_q};

endmodule
